// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and widths for the data-memory responder
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   localparam int DMEM_WORD_W = 32;
   localparam int DMEM_BE_W   = 4;
   localparam int DMEM_CNT_W  = 4;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage, byte-enabled synchronous write, combinational read
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH_WORDS = 256,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                   clk,
   input  logic                   wrEn,
   input  logic [IDX_W-1:0]       wrIdx,
   input  logic [DMEM_WORD_W-1:0] wrData,
   input  logic [DMEM_BE_W-1:0]   wrBe,
   input  logic [IDX_W-1:0]       rdIdx,
   output logic [DMEM_WORD_W-1:0] rdData
);

   logic [DMEM_WORD_W-1:0] mem [DEPTH_WORDS];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         for (int i = 0; i < DMEM_BE_W; i++) begin
            if (wrBe[i]) mem[wrIdx][8*i +: 8] <= wrData[8*i +: 8];
         end
      end
   end

   assign rdData = mem[rdIdx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-programmable data-memory responder; DMEM_ADDR_CHECK_EN enables address error checking
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_we,
   input  logic [31:0]            req_addr,
   input  logic [DMEM_WORD_W-1:0] req_wdata,
   input  logic [DMEM_BE_W-1:0]   req_be,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DMEM_WORD_W-1:0] rsp_rdata,
   output logic                   rsp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(LATENCY - 1);

   dmem_state_t            state, nextState;
   logic [DMEM_CNT_W-1:0]  cnt, cntNext;
   logic                   latWe, latErr;
   logic [IDX_W-1:0]       latIdx;
   logic [IDX_W-1:0]       reqIdx, rdIdx;
   logic [DMEM_WORD_W-1:0] rdData;
   logic                   reqErr, accept, loadRsp, curWe, curErr, wrEn;

   assign reqIdx = req_addr[IDX_W+1:2];

`ifdef DMEM_ADDR_CHECK_EN
   assign reqErr = (req_addr[1:0] != 2'b00) || (req_addr[31:IDX_W+2] != '0);
`else
   logic unusedAddrBits;
   assign unusedAddrBits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
   assign reqErr = 1'b0;
`endif

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign accept    = (state == IDLE) && req_valid;
   assign wrEn      = accept && req_we && !reqErr;

   // With LATENCY=1 the response is built straight from the live request.
   assign curWe  = (state == IDLE) ? req_we : latWe;
   assign curErr = (state == IDLE) ? reqErr : latErr;
   assign rdIdx  = (state == IDLE) ? reqIdx : latIdx;

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) uArray (
      .clk    (clk),
      .wrEn   (wrEn),
      .wrIdx  (reqIdx),
      .wrData (req_wdata),
      .wrBe   (req_be),
      .rdIdx  (rdIdx),
      .rdData (rdData)
   );

   always_comb begin
      nextState = state;
      cntNext   = cnt;
      loadRsp   = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 1) begin
                  nextState = RESP;
                  loadRsp   = 1'b1;
               end else begin
                  nextState = BUSY;
                  cntNext   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            if (cnt <= DMEM_CNT_W'(1)) begin
               nextState = RESP;
               cntNext   = '0;
               loadRsp   = 1'b1;
            end else begin
               cntNext = cnt - DMEM_CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         latWe     <= 1'b0;
         latErr    <= 1'b0;
         latIdx    <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= nextState;
         cnt   <= cntNext;
         if (accept) begin
            latWe  <= req_we;
            latErr <= reqErr;
            latIdx <= reqIdx;
         end
         if (loadRsp) begin
            rsp_rdata <= (curWe || curErr) ? '0 : rdData;
            rsp_err   <= curErr;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench against a word-array reference model
module tb_dmem_responder;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        reqValid, reqWe, rspReady;
   logic [1:0]        reqReady, rspValid, rspErr;
   logic [1:0][31:0]  reqAddr, reqWdata, rspRdata;
   logic [1:0][3:0]   reqBe;

   logic [31:0] model [2][16];
   int passCnt = 0;
   int total   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
      .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
      .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
      .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
   );

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
      .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
      .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
      .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
   );

   function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // Called on a negedge with the instance idle; returns on the negedge after the handshake.
   task automatic doReq(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rdata, output logic err, output int lat);
      int n = 0;
      reqValid[d] = 1'b1; reqWe[d] = we; reqAddr[d] = addr; reqWdata[d] = wdata; reqBe[d] = be;
      while (!reqReady[d] && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      reqValid[d] = 1'b0;
      lat = 1;
      while (!rspValid[d] && lat < 40) begin @(negedge clk); lat++; end
      rdata = rspRdata[d];
      err   = rspErr[d];
      @(negedge clk);
   endtask

   task automatic test_reset();
      total++; if (reqReady !== 2'b11) $display("FAIL reset_req_ready got %b want 11", reqReady); else passCnt++;
      total++; if (rspValid !== 2'b00) $display("FAIL reset_rsp_valid got %b want 00", rspValid); else passCnt++;
      total++; if (rspRdata[0] !== 32'h0 || rspRdata[1] !== 32'h0)
         $display("FAIL reset_rsp_rdata got %h/%h want 0", rspRdata[0], rspRdata[1]); else passCnt++;
      total++; if (rspErr !== 2'b00) $display("FAIL reset_rsp_err got %b want 00", rspErr); else passCnt++;
   endtask

   task automatic test_basic();
      logic [31:0] rd; logic er; int lat;
      doReq(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
      model[0][4] = 32'hDEADBEEF;
      total++; if (lat !== 2) $display("FAIL basic_store_latency got %0d want 2", lat); else passCnt++;
      total++; if (rd !== 32'h0) $display("FAIL basic_store_rdata got %h want 0", rd); else passCnt++;
      total++; if (er !== 1'b0) $display("FAIL basic_store_err got %b want 0", er); else passCnt++;
      doReq(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
      total++; if (lat !== 2) $display("FAIL basic_load_latency got %0d want 2", lat); else passCnt++;
      total++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_load_rdata got %h want deadbeef", rd); else passCnt++;
      doReq(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, er, lat);
      model[0][4] = 32'hDEADBEAA;
      doReq(0, 1'b1, 32'h10, 32'h11223344, 4'b0000, rd, er, lat);
      total++; if (rd !== 32'h0 || lat !== 2) $display("FAIL be0_store_ack got rdata %h lat %0d want 0 lat 2", rd, lat); else passCnt++;
      doReq(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
      total++; if (rd !== 32'hDEADBEAA) $display("FAIL byte_merge_rdata got %h want deadbeaa", rd); else passCnt++;
   endtask

   task automatic test_random();
      logic [31:0] rd, wd, exp; logic er; int lat; int idx; logic we; logic [3:0] be;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) continue;
         wd = $urandom;
         doReq(0, 1'b1, 32'(i * 4), wd, 4'hF, rd, er, lat);
         model[0][i] = wd;
      end
      for (int i = 0; i < 40; i++) begin
         idx = $urandom_range(0, 15);
         we  = 1'($urandom_range(0, 1));
         be  = 4'($urandom_range(0, 15));
         wd  = $urandom;
         exp = we ? 32'h0 : model[0][idx];
         doReq(0, we, 32'(idx * 4), wd, be, rd, er, lat);
         if (we) model[0][idx] = mergeBytes(model[0][idx], wd, be);
         total++; if (rd !== exp || er !== 1'b0 || lat !== 2)
            $display("FAIL random_op%0d got rdata %h err %b lat %0d want %h 0 2", i, rd, er, lat, exp);
         else passCnt++;
      end
   endtask

   task automatic test_stall();
      logic [31:0] r0; int n = 0;
      rspReady[0] = 1'b0;
      reqValid[0] = 1'b1; reqWe[0] = 1'b0; reqAddr[0] = 32'h10; reqBe[0] = 4'hF;
      @(negedge clk);
      reqAddr[0] = 32'h14;
      while (!rspValid[0] && n < 20) begin @(negedge clk); n++; end
      r0 = rspRdata[0];
      total++; if (r0 !== model[0][4]) $display("FAIL stall_first_rdata got %h want %h", r0, model[0][4]); else passCnt++;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++; if (rspValid[0] !== 1'b1 || rspRdata[0] !== r0 || reqReady[0] !== 1'b0)
            $display("FAIL stall_hold%0d got valid %b rdata %h ready %b want 1 %h 0",
                     i, rspValid[0], rspRdata[0], reqReady[0], r0);
         else passCnt++;
      end
      rspReady[0] = 1'b1;
      @(negedge clk);
      total++; if (reqReady[0] !== 1'b1 || rspValid[0] !== 1'b0)
         $display("FAIL stall_release got ready %b valid %b want 1 0", reqReady[0], rspValid[0]); else passCnt++;
      @(negedge clk);
      total++; if (reqReady[0] !== 1'b0) $display("FAIL stall_next_accept got ready %b want 0", reqReady[0]); else passCnt++;
      reqValid[0] = 1'b0;
      n = 0;
      while (!rspValid[0] && n < 20) begin @(negedge clk); n++; end
      total++; if (rspRdata[0] !== model[0][5]) $display("FAIL stall_second_rdata got %h want %h", rspRdata[0], model[0][5]); else passCnt++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat; int seen = 0;
      for (int k = 0; k < 2; k++) begin
         reqValid[0] = 1'b1; reqWe[0] = (k == 0); reqAddr[0] = 32'h20;
         reqWdata[0] = 32'hCAFEF00D; reqBe[0] = 4'hF;
         @(negedge clk);
         reqValid[0] = 1'b0;
         if (k == 0) model[0][8] = 32'hCAFEF00D;
         reset = 1'b0;
         #1;
         total++; if (reqReady[0] !== 1'b1 || rspValid[0] !== 1'b0)
            $display("FAIL reset_mid%0d got ready %b valid %b want 1 0", k, reqReady[0], rspValid[0]); else passCnt++;
         @(negedge clk);
         reset = 1'b1;
         for (int i = 0; i < 6; i++) begin @(negedge clk); if (rspValid[0]) seen++; end
         total++; if (seen !== 0) $display("FAIL reset_mid%0d_no_rsp got %0d responses want 0", k, seen); else passCnt++;
      end
      doReq(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
      total++; if (rd !== model[0][8]) $display("FAIL reset_store_kept got %h want %h", rd, model[0][8]); else passCnt++;
   endtask

   task automatic test_addr_check();
      logic [31:0] rd; logic er; int lat;
`ifdef DMEM_ADDR_CHECK_EN
      doReq(0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
      total++; if (er !== 1'b1 || rd !== 32'h0 || lat !== 2)
         $display("FAIL misaligned_load got err %b rdata %h lat %0d want 1 0 2", er, rd, lat); else passCnt++;
      doReq(0, 1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat);
      total++; if (er !== 1'b1 || lat !== 2) $display("FAIL range_store got err %b lat %0d want 1 2", er, lat); else passCnt++;
`else
      doReq(0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
      total++; if (er !== 1'b0 || rd !== model[0][4])
         $display("FAIL lowbits_ignored got err %b rdata %h want 0 %h", er, rd, model[0][4]); else passCnt++;
      doReq(0, 1'b1, 32'h400, 32'h12345678, 4'hF, rd, er, lat);
      model[0][0] = 32'h12345678;
      total++; if (er !== 1'b0) $display("FAIL wrap_store_err got %b want 0", er); else passCnt++;
`endif
      doReq(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, er, lat);
      total++; if (rd !== model[0][0] || er !== 1'b0)
         $display("FAIL word0_after_0x400 got %h err %b want %h 0", rd, er, model[0][0]); else passCnt++;
   endtask

   task automatic test_latency1();
      logic [31:0] rd, wd; logic er; int lat; int idx; logic [31:0] pend;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         doReq(1, 1'b1, 32'(i * 4), wd, 4'hF, rd, er, lat);
         model[1][i] = wd;
      end
      total++; if (lat !== 1) $display("FAIL lat1_store_latency got %0d want 1", lat); else passCnt++;
      pend = 32'h0;
      for (int i = 0; i < 12; i++) begin
         total++; if (reqReady[1] !== 1'(i % 2 == 0) || rspValid[1] !== 1'(i % 2 == 1))
            $display("FAIL b2b_cycle%0d got ready %b valid %b want %b %b",
                     i, reqReady[1], rspValid[1], 1'(i % 2 == 0), 1'(i % 2 == 1));
         else passCnt++;
         if (i % 2 == 1) begin
            total++; if (rspRdata[1] !== pend) $display("FAIL b2b_rdata%0d got %h want %h", i, rspRdata[1], pend); else passCnt++;
         end
         if (i % 2 == 0) begin
            idx = $urandom_range(0, 15);
            reqValid[1] = 1'b1; reqWe[1] = 1'b0; reqAddr[1] = 32'(idx * 4); reqBe[1] = 4'($urandom);
            pend = model[1][idx];
         end
         if (i == 11) reqValid[1] = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b0;
      reqValid = '0; reqWe = '0; reqAddr = '0; reqWdata = '0; reqBe = '0; rspReady = 2'b11;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b1;
      @(negedge clk);
      test_basic();
      test_random();
      test_stall();
      test_reset_mid();
      test_addr_check();
      test_latency1();
      $display("%0d/%0d checks passed", passCnt, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout after %0d checks want completion", total);
      $fatal(1);
   end

endmodule
